serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request a subtraction; sampled on rising clk edges.
REQ-006 Port: a  input  WIDTH  minuend, unsigned; sampled only on the edge that accepts start.
REQ-007 Port: b  input  WIDTH  subtrahend, unsigned; sampled only on the edge that accepts start.
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  one-cycle pulse; diff and borrow are final.
REQ-010 Port: diff  output  WIDTH  result a - b modulo 2^WIDTH.
REQ-011 Port: borrow  output  1  final borrow-out; high when a < b.

Function
REQ-012 Arithmetic SHALL be bit-serial, LSB first, one bit per clock, using a full subtractor: d = ai ^ bi ^ bin; bout = (~ai & bi) | (~(ai ^ bi) & bin).
REQ-013 The borrow-in for bit 0 SHALL be 0; the borrow between bits SHALL be held in a single flip-flop.
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE -> SHIFT on a rising edge with start=1. On that edge a and b load into internal shift registers, the bit counter clears to 0 and the borrow flop clears to 0.
REQ-016 In SHIFT, each edge SHALL compute one bit from the shift-register LSBs and the borrow flop, shift d into the result register from the MSB side, shift both operand registers right, and increment the counter.
REQ-017 SHIFT -> DONE on the edge that processes bit WIDTH-1, which is the WIDTH-th edge after the accepting edge.
REQ-018 DONE -> IDLE unconditionally on the next edge.
REQ-019 busy SHALL be 1 exactly while in SHIFT, which is WIDTH cycles.
REQ-020 done SHALL be 1 exactly while in DONE, which is one cycle. done rises on the WIDTH-th edge after the accepting edge.
REQ-021 diff and borrow SHALL be registered, updated only on the edge entering DONE, and held unchanged until the next entry to DONE or reset.
REQ-022 diff and borrow SHALL NOT show partial results while busy=1.
REQ-023 start SHALL be ignored in SHIFT and in DONE; no queuing; a, b, diff and borrow are unaffected.
REQ-024 start held high continuously SHALL produce back-to-back operations, each starting from IDLE, with a period of WIDTH+2 cycles.
REQ-025 Operand changes on a and b after the accepting edge SHALL NOT affect the in-flight result.
REQ-026 Boundary: a = b gives diff = 0 and borrow = 0.
REQ-027 Boundary: a = 0 with b ≠ 0 gives borrow = 1 and diff = 2^WIDTH - b.
REQ-028 Boundary: all-ones minus all-ones gives 0 and borrow = 0.
REQ-029 The counter SHALL be sized ceil(log2(WIDTH)) or wider, with no wrap inside one operation.

Reset
REQ-030 rst_n low SHALL immediately, without waiting for clk, force the state to IDLE.
REQ-031 rst_n low SHALL immediately force busy=0, done=0, diff=0 and borrow=0.
REQ-032 rst_n low SHALL immediately clear the counter, the operand shift registers, the result register and the borrow flop.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-034 After rst_n deasserts, the first start seen at a rising edge SHALL be accepted normally.

Verification (WIDTH=8)
REQ-035 a=100, b=37, start pulse -> busy for 8 cycles, then done for 1 cycle with diff=63 and borrow=0.
REQ-036 a=37, b=100 -> diff=193 (0xC1), borrow=1. a=0x00, b=0x01 -> diff=0xFF, borrow=1.
REQ-037 a=0x55, b=0x55 -> diff=0x00, borrow=0. a=0xFF, b=0x00 -> diff=0xFF, borrow=0.
REQ-038 Test start ignored while busy: first op a=200, b=50, then start with a=1, b=2 on busy cycle 3 -> single done with diff=150 and borrow=0; no second done.
REQ-039 Test a changed after accept: a changed on the cycle after accept -> result reflects the original operands.
REQ-040 Test reset mid-operation: rst_n low between edges in busy cycle 4 -> busy, done, diff and borrow go to 0 asynchronously; no done pulse follows. The next op a=10, b=3 -> diff=7 and borrow=0.
REQ-041 Test continuous start: start held high for 3 operations -> done pulses spaced exactly 10 cycles apart.
REQ-042 Randomized self-check: 1000 random a, b pairs -> {borrow, diff} equals {a < b, (a - b) mod 256} at every done.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one bit per clock.
// A full subtractor consumes the operand shift-register LSBs plus a single
// borrow flop. Results become visible only when the last bit has been processed.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // The counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits are
    // enough. It holds at its last value, so it never wraps within an operation.
    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             ai;
    logic             bi;
    logic             d_d;
    logic             bout_d;
    logic [WIDTH-1:0] res_d;

    // Full subtractor on the current LSBs; the result register fills from the MSB side
    always_comb begin
        ai     = a_q[0];
        bi     = b_q[0];
        d_d    = ai ^ bi ^ bin_q;
        bout_d = (~ai & bi) | (~(ai ^ bi) & bin_q);
        res_d  = {d_d, res_q[WIDTH-1:1]};
    end

    // Control FSM and datapath; outputs are registered and change only on state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        bin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // start is ignored here: no queuing, operands stay untouched
                    res_q <= res_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    bin_q <= bout_d;
                    if (cnt_q == LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= bout_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    // One-cycle pulse. A start seen here is dropped; a held start is
                    // picked up from IDLE on the following edge.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
